// File: rtl/uart_password_sequencer.sv
// Plays an N-character password into the chip as back-to-back 8N1 UART frames,
// then classifies the chip's LED response as pass, fail or timeout.
module uart_password_sequencer #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int N_CHARS      = 8,
  parameter int RESP_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [8*N_CHARS-1:0] password,
  output logic                 tx,
  input  logic                 led_g_n,
  input  logic                 led_r_n,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout
);
  // state     | meaning
  // IDLE      | line high, waiting for start
  // START_BIT | tx low for one bit period
  // DATA_BITS | 8 data bits, LSB first
  // STOP_BIT  | tx high; LEDs recorded during the last character's stop bit
  // WAIT_RESP | waiting for an LED or the response timeout
  // REPORT    | one-cycle done pulse with the result flags
  localparam int BAUD_P = CLK_HZ / BAUD;
  localparam int BW     = (BAUD_P > 1) ? $clog2(BAUD_P) : 1;
  localparam int TW     = $clog2(RESP_TIMEOUT + 1);
  localparam int PW     = 8 * N_CHARS;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_P - 1);
  localparam logic [3:0]    LAST_CHAR = 4'(N_CHARS - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_RESP, REPORT
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      char_q, char_d;
  logic [TW-1:0]   to_q, to_d;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic            led_g_q, led_r_q;
  logic            seen_g_q, seen_g_d, seen_r_q, seen_r_d;
  logic            tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic            pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic            bit_end, last_char;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    char_d    = char_q;
    to_d      = to_q;
    shadow_d  = shadow_q;
    seen_g_d  = seen_g_q;
    seen_r_d  = seen_r_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    bit_end   = (baud_q == BAUD_LAST);
    last_char = (char_q == LAST_CHAR);

    if (state_q inside {START_BIT, DATA_BITS, STOP_BIT})
      baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = START_BIT;
          shadow_d  = password;
          baud_d    = '0;
          bit_d     = '0;
          char_d    = '0;
          to_d      = '0;
          seen_g_d  = 1'b0;
          seen_r_d  = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) state_d = DATA_BITS;
      end
      DATA_BITS: begin
        // The shadow shifts right so the next bit to send is always at bit 0.
        if (bit_end) begin
          shadow_d = {1'b0, shadow_q[PW-1:1]};
          bit_d    = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (last_char) begin
          if (!led_r_q) seen_r_d = 1'b1;
          if (!led_g_q) seen_g_d = 1'b1;
        end
        if (bit_end) begin
          if (last_char) begin
            state_d = WAIT_RESP;
          end else begin
            char_d  = char_q + 1'b1;
            state_d = START_BIT;
          end
        end
      end
      WAIT_RESP: begin
        to_d = to_q + 1'b1;
        // Limit is the full count, so done lands RESP_TIMEOUT+1 cycles after entry.
        if (!led_r_q || seen_r_q) begin
          fail_d  = 1'b1;
          state_d = REPORT;
        end else if (!led_g_q || seen_g_q) begin
          pass_d  = 1'b1;
          state_d = REPORT;
        end else if (to_q == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == START_BIT)      tx_d = 1'b0;
    else if (state_d == DATA_BITS) tx_d = shadow_d[0];
    busy_d = state_d inside {START_BIT, DATA_BITS, STOP_BIT, WAIT_RESP};
    done_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      char_q    <= '0;
      to_q      <= '0;
      shadow_q  <= '0;
      led_g_q   <= 1'b1;
      led_r_q   <= 1'b1;
      seen_g_q  <= 1'b0;
      seen_r_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      char_q    <= char_d;
      to_q      <= to_d;
      shadow_q  <= shadow_d;
      led_g_q   <= led_g_n;
      led_r_q   <= led_r_n;
      seen_g_q  <= seen_g_d;
      seen_r_q  <= seen_r_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_uart_password_sequencer.sv
// Bench for uart_password_sequencer: timestamp-based model compared every cycle,
// an independent UART decoder on tx, and directed scenarios with literal latencies.
module tb_uart_password_sequencer;
  localparam int B  = 104;
  localparam int N  = 8;
  localparam int T  = 4096;
  localparam int FL = 10 * B * N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic led_g_n = 1'b1;
  logic led_r_n = 1'b1;
  logic [8*N-1:0] password = '0;
  logic tx, busy, done, pass, fail, timeout;

  uart_password_sequencer #(
    .CLK_HZ(12000000), .BAUD(115200), .N_CHARS(N), .RESP_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .password(password),
    .tx(tx), .led_g_n(led_g_n), .led_r_n(led_r_n), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;

  // Model: expected outputs from time since acceptance and captured LED history.
  bit   m_act = 1'b0, m_rep = 1'b0, seen_r = 1'b0, seen_g = 1'b0;
  bit   pr_r = 1'b1, pr_g = 1'b1;
  int   m_t = 0;
  bit   m_frame [$];
  logic e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  logic e_pass = 1'b0, e_fail = 1'b0, e_to = 1'b0;

  // Independent UART receiver on tx.
  logic [7:0] rx_q [$];
  logic [7:0] rx_b;
  int fe_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        if (tx !== 1'b0) fe_cnt++;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          rx_b = {tx, rx_b[7:1]};
        end
        repeat (B) @(negedge clk);
        if (tx !== 1'b1) fe_cnt++;
        rx_q.push_back(rx_b);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int r;
    logic [8*N-1:0] sh;
    if (!reset_n) begin
      m_act = 1'b0; m_rep = 1'b0; seen_r = 1'b0; seen_g = 1'b0;
      pr_r = 1'b1; pr_g = 1'b1; m_t = 0;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      e_pass = 1'b0; e_fail = 1'b0; e_to = 1'b0;
      return;
    end
    e_done = 1'b0;
    r = 0;
    if (m_rep) begin
      m_rep = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1; m_t = 0; seen_r = 1'b0; seen_g = 1'b0;
        e_pass = 1'b0; e_fail = 1'b0; e_to = 1'b0;
        m_frame.delete();
        sh = password;
        for (int c = 0; c < N; c++) begin
          m_frame.push_back(1'b0);
          for (int j = 0; j < 8; j++) begin
            m_frame.push_back(sh[0]);
            sh = sh >> 1;
          end
          m_frame.push_back(1'b1);
        end
      end
    end else begin
      m_t++;
      if (m_t - 1 >= FL - B && m_t - 1 < FL) begin
        if (!pr_r) seen_r = 1'b1;
        if (!pr_g) seen_g = 1'b1;
      end else if (m_t - 1 >= FL) begin
        if (!pr_r || seen_r) r = 2;
        else if (!pr_g || seen_g) r = 1;
        else if (m_t - 1 - FL == T) r = 3;
      end
      if (r != 0) begin
        m_act = 1'b0; m_rep = 1'b1; e_done = 1'b1;
        e_pass = (r == 1); e_fail = (r == 2); e_to = (r == 3);
      end
    end
    e_busy = m_act;
    e_tx = (m_act && m_t < FL) ? m_frame[m_t / B] : 1'b1;
    pr_r = led_r_n;
    pr_g = led_g_n;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    if (done === 1'b1) n_done++;
    check("outputs{tx,busy,done,pass,fail,timeout}",
          32'({tx, busy, done, pass, fail, timeout}),
          32'({e_tx, e_busy, e_done, e_pass, e_fail, e_to}));
  endtask

  task automatic wait_until(input int x);
    while (cyc < x) tick();
  endtask

  task automatic wait_done(input int max, output int d);
    d = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done within %0d cycles", max);
    end
  endtask

  task automatic start_run(input logic [8*N-1:0] pw, output int p0, output int base);
    base = rx_q.size();
    password = pw;
    start = 1'b1;
    tick();
    start = 1'b0;
    p0 = cyc;
    check("start_latency{busy,tx}", 32'({busy, tx}), 32'(2'b10));
  endtask

  task automatic check_bytes(input string name, input int base, input logic [8*N-1:0] pw);
    logic [8*N-1:0] sh;
    logic [7:0] got;
    sh = pw;
    check({name, "_byte_count"}, rx_q.size() - base, N);
    for (int c = 0; c < N; c++) begin
      got = (base + c < rx_q.size()) ? rx_q[base + c] : 8'hxx;
      check({name, "_byte"}, 32'(got), 32'(sh[7:0]));
      sh = sh >> 8;
    end
  endtask

  task automatic run_case(input string name, input logic [8*N-1:0] pw, input bit use_g,
                          input bit use_r, input int led_at, input int exp_lat,
                          input logic [2:0] exp_flags);
    int p0, base, d;
    start_run(pw, p0, base);
    if (use_g || use_r) begin
      wait_until(p0 + FL + led_at);
      if (use_g) led_g_n = 1'b0;
      if (use_r) led_r_n = 1'b0;
    end
    wait_done(FL + T + 100, d);
    check({name, "_done_latency"}, d - (p0 + FL), exp_lat);
    check({name, "_flags{pass,fail,timeout}"}, 32'({pass, fail, timeout}), 32'(exp_flags));
    led_g_n = 1'b1;
    led_r_n = 1'b1;
    check_bytes(name, base, pw);
    repeat (4) tick();
  endtask

  initial begin
    int p0, base, d, nd;
    logic [8*N-1:0] pw0;
    pw0 = 64'h0123_4567_89AB_CDEF;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset_outputs", 32'({tx, busy, done, pass, fail, timeout}), 32'(6'b100000));

    // Correct password, green 10 cycles after the last stop bit.
    run_case("pass", pw0, 1'b1, 1'b0, 10, 12, 3'b100);
    check("pass_first_byte", 32'(rx_q[0]), 32'(8'hEF));
    check("pass_last_byte", 32'(rx_q[7]), 32'(8'h01));

    run_case("fail_red", 64'hDEAD_BEEF_00C0_FFEE, 1'b0, 1'b1, 5, 7, 3'b010);
    run_case("timeout", 64'h5A5A_A5A5_0F0F_F0F0, 1'b0, 1'b0, 0, 4097, 3'b001);
    run_case("both_leds", 64'hFFFF_0000_8001_7FFE, 1'b1, 1'b1, 20, 22, 3'b010);

    // Green pulse during char 3 lies outside the sampling window.
    start_run(pw0, p0, base);
    wait_until(p0 + 3 * 10 * B + 500);
    led_g_n = 1'b0;
    repeat (10) tick();
    led_g_n = 1'b1;
    wait_done(FL + T + 100, d);
    check("early_green_latency", d - (p0 + FL), 4097);
    check("early_green_flags", 32'({pass, fail, timeout}), 32'(3'b001));
    repeat (4) tick();

    // Second start and password change mid-frame are both ignored.
    nd = n_done;
    start_run(pw0, p0, base);
    wait_until(p0 + 4 * 10 * B + 100);
    password = 64'h1122_3344_5566_7788;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(p0 + FL + 3);
    led_g_n = 1'b0;
    wait_done(FL + T + 100, d);
    led_g_n = 1'b1;
    check("restart_ignored_latency", d - (p0 + FL), 5);
    repeat (200) tick();
    check("restart_single_done", n_done - nd, 1);
    check_bytes("restart_ignored", base, pw0);

    // Reset during a zero data bit of char 2 (0xAB, bit 2).
    start_run(pw0, p0, base);
    wait_until(p0 + 2 * 10 * B + 3 * B + 50);
    check("pre_reset_tx", 32'(tx), 32'(1'b0));
    nd = n_done;
    reset_n = 1'b0;
    #1;
    check("async_reset_{tx,busy}", 32'({tx, busy}), 32'(2'b10));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2000) tick();
    check("no_done_after_reset", n_done - nd, 0);
    run_case("after_reset", pw0, 1'b1, 1'b0, 10, 12, 3'b100);

    check("framing_errors", fe_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
